adc_logicomp_gen: RTL and testbench

- Parametrised successor of the ADC output-compilation logic.
- Samples a DATA_W-bit ADC code on a programmable-rate internal tick and compiles it according to a 2-bit mode: bypass, windowed average, windowed peak-max or windowed peak-min.
- Emits the result with a one-cycle valid strobe.
- Sits between the ADC comparator/code bus and the user-project IO pads / wishbone readout.

---
 rtl/adc_logicomp_gen.sv | 86 ++++++++
 tb/tb_adc_logicomp_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/adc_logicomp_gen.sv
// adc_logicomp_gen: samples an ADC code on a programmable-rate tick and compiles it (bypass/average/max/min)
// Ports:
//   wb_clk_i  system clock, rising edge
//   wb_rst_n  asynchronous active-low reset
//   en_i      block enable; low idles and flushes the window
//   mode_i    00 bypass, 01 average, 10 max, 11 min
//   div_i     sample period minus one, in clocks
//   adc_i     raw ADC code
//   data_o    compiled result, registered
//   valid_o   one-cycle pulse when data_o updates
//   busy_o    window partially filled (windowed modes only)
module adc_logicomp_gen #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 2,
  parameter int DIV_W    = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DATA_W-1:0] adc_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_AVG = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_ext;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_mode;
  logic                r_valid;
  logic                w_tick;
  logic                w_flush;
  logic                w_last;
  logic [ACC_W-1:0]    w_sum;
  logic [DATA_W-1:0]   w_ext;
  assign w_tick  = en_i && (r_div_cnt == div_i);
  assign w_flush = r_mode != mode_i;
  assign w_last  = r_cnt == {AVG_LOG2{1'b1}};
  assign w_sum   = r_acc + ACC_W'(adc_i);
  // first sample of a window loads the extreme unconditionally
  assign w_ext   = (r_cnt == '0) ? adc_i :
                   (r_mode == MODE_MAX) ? ((adc_i > r_ext) ? adc_i : r_ext) :
                                          ((adc_i < r_ext) ? adc_i : r_ext);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_div_cnt <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ext     <= '0;
      r_data    <= '0;
      r_mode    <= MODE_BYP;
      r_valid   <= 1'b0;
    end else begin
      r_mode    <= mode_i;
      r_valid   <= 1'b0;
      r_div_cnt <= (!en_i || w_tick) ? '0 : r_div_cnt + 1'b1;
      // a mode change drops the partial window and any sample ticking this cycle
      if (!en_i || w_flush) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_ext <= '0;
      end else if (w_tick && r_mode != MODE_BYP) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_last ? '0 : w_sum;
        r_ext <= w_last ? '0 : w_ext;
        if (w_last) begin
          r_valid <= 1'b1;
          r_data  <= (r_mode == MODE_AVG) ? w_sum[ACC_W-1:AVG_LOG2] : w_ext;
        end
      end else if (w_tick) begin
        r_valid <= 1'b1;
        r_data  <= adc_i;
      end
    end
  end
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy_o  = (r_mode != MODE_BYP) && (r_cnt != '0);
endmodule

// File: tb/tb_adc_logicomp_gen.sv
// tb_adc_logicomp_gen: directed vector bench for adc_logicomp_gen
module tb_adc_logicomp_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] div = 4'd0;
  logic [9:0] adc = 10'd0;
  logic [9:0] data;
  logic       valid;
  logic       busy;
  int n_vec = 0;
  int n_err = 0;
  adc_logicomp_gen #(.DATA_W(10), .AVG_LOG2(2), .DIV_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
    .adc_i(adc), .data_o(data), .valid_o(valid), .busy_o(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       e;
    logic [1:0] m;
    logic [9:0] a;
    logic [9:0] d;
    logic       v;
    logic       b;
  } vec_t;
  vec_t tbl[22];
  task automatic expect_out(input string name, input logic [9:0] d, input logic v, input logic b);
    n_vec++;
    if ({data, valid, busy} !== {d, v, b}) begin
      n_err++;
      $display("FAIL %s: got data=%0d valid=%b busy=%b, want data=%0d valid=%b busy=%b",
               name, data, valid, busy, d, v, b);
    end
  endtask
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] dv, input logic [9:0] a);
    en = e; mode = m; div = dv; adc = a;
    @(posedge clk);
    #1;
  endtask
  task automatic window(input string name, input logic [1:0] m, input logic [3:0] dv,
                        input logic [9:0] s[4], input logic [9:0] prev, input logic [9:0] res);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c <= int'(dv); c++) begin
        step(1'b1, m, dv, s[k]);
        if (c < int'(dv))
          expect_out($sformatf("%s_s%0d_c%0d", name, k, c), prev, 1'b0, k != 0);
        else if (k < 3)
          expect_out($sformatf("%s_s%0d", name, k), prev, 1'b0, 1'b1);
        else
          expect_out($sformatf("%s_done", name), res, 1'b1, 1'b0);
      end
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd0, 10'h17F, 10'h17F, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 10'h2A5, 10'h2A5, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 10'd100, 10'h3FF, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 10'd100, 10'h3FF, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'd1, 10'd200, 10'h3FF, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2'd1, 10'd300, 10'h3FF, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'd1, 10'd401, 10'd250, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd1, 10'd1023, 10'd250, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 2'd1, 10'd1023, 10'd250, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 10'd1023, 10'd250, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 2'd1, 10'd1023, 10'd1023, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 10'd5, 10'd1023, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 10'd5, 10'd1023, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 2'd2, 10'd900, 10'd1023, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 2'd2, 10'd12, 10'd1023, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 2'd2, 10'd899, 10'd900, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 2'd3, 10'd5, 10'd900, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 2'd3, 10'd5, 10'd900, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 2'd3, 10'd900, 10'd900, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 2'd3, 10'd12, 10'd900, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 2'd3, 10'd899, 10'd5, 1'b1, 1'b0};
    #12;
    expect_out("reset_state", 10'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].e, tbl[i].m, 4'd0, tbl[i].a);
      expect_out($sformatf("tbl%0d", i), tbl[i].d, tbl[i].v, tbl[i].b);
    end
    step(1'b0, 2'd2, 4'd3, 10'd0);
    expect_out("max_div3_prep", 10'd5, 1'b0, 1'b0);
    window("max_div3", 2'd2, 4'd3, '{10'd5, 10'd900, 10'd12, 10'd899}, 10'd5, 10'd900);
    step(1'b0, 2'd3, 4'd3, 10'd0);
    expect_out("min_div3_prep", 10'd900, 1'b0, 1'b0);
    window("min_div3", 2'd3, 4'd3, '{10'd5, 10'd900, 10'd12, 10'd899}, 10'd900, 10'd5);
    step(1'b0, 2'd1, 4'd0, 10'd0);
    expect_out("endrop_prep", 10'd5, 1'b0, 1'b0);
    step(1'b1, 2'd1, 4'd0, 10'd50);
    expect_out("endrop_s0", 10'd5, 1'b0, 1'b1);
    step(1'b1, 2'd1, 4'd0, 10'd60);
    expect_out("endrop_s1", 10'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd1, 4'd0, 10'd70);
      expect_out($sformatf("endrop_low%0d", i), 10'd5, 1'b0, 1'b0);
    end
    window("reenable", 2'd1, 4'd0, '{10'd8, 10'd8, 10'd8, 10'd8}, 10'd5, 10'd8);
    step(1'b1, 2'd1, 4'd0, 10'd10);
    expect_out("modesw_s0", 10'd8, 1'b0, 1'b1);
    step(1'b1, 2'd1, 4'd0, 10'd20);
    expect_out("modesw_s1", 10'd8, 1'b0, 1'b1);
    step(1'b1, 2'd1, 4'd0, 10'd30);
    expect_out("modesw_s2", 10'd8, 1'b0, 1'b1);
    step(1'b1, 2'd2, 4'd0, 10'd40);
    expect_out("modesw_flush", 10'd8, 1'b0, 1'b0);
    window("modesw_max", 2'd2, 4'd0, '{10'd7, 10'd1000, 10'd3, 10'd2}, 10'd8, 10'd1000);
    step(1'b1, 2'd1, 4'd0, 10'd100);
    expect_out("rst_flush", 10'd1000, 1'b0, 1'b0);
    step(1'b1, 2'd1, 4'd0, 10'd100);
    expect_out("rst_s0", 10'd1000, 1'b0, 1'b1);
    step(1'b1, 2'd1, 4'd0, 10'd100);
    expect_out("rst_s1", 10'd1000, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 10'd0, 1'b0, 1'b0);
    en = 1'b0;
    @(posedge clk);
    #1;
    expect_out("rst_held", 10'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 2'd1, 4'd0, 10'd0);
    expect_out("rst_release", 10'd0, 1'b0, 1'b0);
    window("post_rst", 2'd1, 4'd0, '{10'd40, 10'd40, 10'd40, 10'd40}, 10'd0, 10'd40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
